// File: rtl/multicycle_core.sv
// multicycle_core: fetch/execute/writeback core for the 9-bit ISA with external instruction and data memories
module multicycle_core #(
  parameter int W  = 8,
  parameter int D  = 10,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  start_pc,
  input  logic [D-1:0]  end_pc,
  output logic [D-1:0]  imem_addr,
  input  logic [8:0]    imem_data,
  output logic [W-1:0]  dmem_addr,
  output logic [W-1:0]  dmem_wdata,
  output logic          dmem_we,
  output logic          dmem_re,
  input  logic [W-1:0]  dmem_rdata,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycles,
  output logic [CW-1:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, DONE} state_t;
  localparam logic [2:0] OP_XOR = 3'b000, OP_BEQ = 3'b001, OP_ADDI = 3'b010, OP_ANDI = 3'b011;
  localparam logic [2:0] OP_LS = 3'b100, OP_LD = 3'b101, OP_ST = 3'b110, OP_J = 3'b111;
  state_t state, nextState;
  logic [D-1:0] pc, endPc, execPc;
  logic [8:0] ir;
  logic [W-1:0] regs [8];
  logic [2:0] op, ra, rb;
  logic [W-1:0] valA, valB, imm, aluOut, wrData;
  logic accept, atEnd, isLd, isAlu, wrReg, retire;
  assign op = ir[8:6];
  assign ra = ir[5:3];
  assign rb = ir[2:0];
  assign valA = regs[ra];
  assign valB = regs[rb];
  assign imm = {{(W-3){1'b0}}, rb};
  assign accept = (state == IDLE || state == DONE) && start;
  assign atEnd = pc == endPc;
  assign isLd = op == OP_LD;
  assign isAlu = op inside {OP_XOR, OP_ADDI, OP_ANDI, OP_LS};
  assign aluOut = op == OP_XOR ? valA ^ valB :
                  op == OP_ADDI ? valA + imm :
                  op == OP_ANDI ? valA & imm : valA << rb;
  // Next PC out of EXEC: page-relative jump, signed-offset branch, or sequential.
  assign execPc = op == OP_J ? {pc[D-1:6], ir[5:0]} :
                  op == OP_BEQ && valA == '0 ? pc + D'(1) + {{(D-3){rb[2]}}, rb} : pc + D'(1);
  assign wrReg = (state == EXEC && isAlu) || state == WB;
  assign wrData = state == WB ? dmem_rdata : aluOut;
  assign retire = (state == EXEC && !isLd) || state == WB;
  assign imem_addr = pc;
  // State register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;
  // Next state and decoded outputs; strobes derive from state so reset drops them at once.
  always_comb begin
    nextState = state;
    busy = 1'b0;
    done = 1'b0;
    dmem_we = 1'b0;
    dmem_re = 1'b0;
    case (state)
      IDLE: nextState = start ? FETCH : IDLE;
      FETCH: begin
        busy = 1'b1;
        nextState = atEnd ? DONE : EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        dmem_we = op == OP_ST;
        dmem_re = isLd;
        nextState = isLd ? WB : FETCH;
      end
      WB: begin
        busy = 1'b1;
        nextState = FETCH;
      end
      DONE: begin
        done = 1'b1;
        nextState = start ? FETCH : DONE;
      end
      default: nextState = IDLE;
    endcase
    dmem_addr = dmem_we || dmem_re ? valB : '0;
    dmem_wdata = dmem_we ? valA : '0;
  end
  // Datapath: PC, run bounds, instruction register, register file and run counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      endPc <= '0;
      ir <= '0;
      cycles <= '0;
      retired <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (accept) begin
        pc <= start_pc;
        endPc <= end_pc;
        cycles <= '0;
        retired <= '0;
      end else begin
        cycles <= busy ? cycles + CW'(1) : cycles;
        retired <= retire ? retired + CW'(1) : retired;
      end
      if (state == FETCH && !atEnd) ir <= imem_data;
      if (state == EXEC && !isLd) pc <= execPc;
      if (state == WB) pc <= pc + D'(1);
      if (wrReg) regs[ra] <= wrData;
    end
  end
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed and randomized checks of multicycle_core against an instruction-level model
module tb_multicycle_core;
  localparam int W = 8, D = 10, CW = 32;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, loadMem = 1'b1;
  logic [D-1:0] start_pc = '0, end_pc = '0, imem_addr;
  logic [8:0] imem_data;
  logic [W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic dmem_we, dmem_re, busy, done;
  logic [CW-1:0] cycles, retired;
  logic [8:0] imem [1024];
  logic [7:0] dmem [256];
  logic [7:0] initMem [256];
  int total = 0, bad = 0;
  int mR [8];
  int mDmem [256];
  int expQ [$];
  int gotQ [$];

  multicycle_core #(.W(W), .D(D), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .end_pc(end_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
    .busy(busy), .done(done), .cycles(cycles), .retired(retired)
  );

  always #5 clk = ~clk;
  assign imem_data = imem[imem_addr];

  // Data memory with one-cycle read latency; every store is logged as addr*256+data.
  always @(posedge clk) begin
    if (loadMem) for (int i = 0; i < 256; i++) dmem[i] <= initMem[i];
    else if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
      gotQ.push_back(int'({dmem_addr, dmem_wdata}));
    end
    if (dmem_re) dmem_rdata <= dmem[dmem_addr];
  end

  function automatic logic [8:0] ins(input int op, input int a, input int b);
    return 9'(op * 64 + a * 8 + b);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Instruction-level interpreter: one loop iteration per instruction, plain integer arithmetic.
  task automatic modelRun(input int sp, input int ep, output int ret, output int cyc, output int sts, output int lds);
    int pc, nxt, word, op, a, b;
    pc = sp; ret = 0; cyc = 1; sts = 0; lds = 0;
    while (pc != ep && ret < 1000) begin
      word = int'(imem[pc]);
      op = word / 64; a = (word / 8) % 8; b = word % 8;
      nxt = (pc + 1) % 1024;
      ret++;
      cyc += (op == 5) ? 3 : 2;
      case (op)
        0: mR[a] = mR[a] ^ mR[b];
        1: if (mR[a] == 0) nxt = (pc + 1 + (b >= 4 ? b - 8 : b) + 1024) % 1024;
        2: mR[a] = (mR[a] + b) % 256;
        3: mR[a] = mR[a] & b;
        4: mR[a] = (mR[a] << b) % 256;
        5: begin mR[a] = mDmem[mR[b]]; lds++; end
        6: begin mDmem[mR[b]] = mR[a]; expQ.push_back(mR[b] * 256 + mR[a]); sts++; end
        default: nxt = pc - pc % 64 + word % 64;
      endcase
      pc = nxt;
    end
  endtask

  task automatic runProg(input string tag, input int sp, input int ep, input bit poke, output int lat);
    int ret, cyc, sts, lds, weN, reN, clash, eBase;
    eBase = expQ.size();
    modelRun(sp, ep, ret, cyc, sts, lds);
    @(negedge clk); start_pc = D'(sp); end_pc = D'(ep); start = 1'b1;
    @(negedge clk); start = 1'b0; start_pc = D'($urandom); end_pc = D'($urandom);
    lat = 1; weN = 0; reN = 0; clash = 0;
    while (!done && lat < 5000) begin
      weN += int'(dmem_we);
      reN += int'(dmem_re);
      clash += int'((dmem_we && dmem_re) || (busy == done));
      start = poke && (lat == 2);
      @(negedge clk); lat++;
    end
    start = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_retired"}, 64'(retired), 64'(ret));
    chk({tag, "_cycles"}, 64'(cycles), 64'(cyc));
    chk({tag, "_pc"}, 64'(imem_addr), 64'(ep));
    chk({tag, "_latency"}, 64'(lat), 64'(cyc + 1));
    chk({tag, "_we_cycles"}, 64'(weN), 64'(sts));
    chk({tag, "_re_cycles"}, 64'(reN), 64'(lds));
    chk({tag, "_overlap"}, 64'(clash), 64'(0));
    chk({tag, "_stores"}, 64'(gotQ.size()), 64'(expQ.size()));
    for (int k = eBase; k < expQ.size(); k++) chk({tag, "_store"}, 64'(gotQ[k]), 64'(expQ[k]));
  endtask

  initial begin
    int lat, gb, base, rop;
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    for (int i = 0; i < 256; i++) begin
      initMem[i] = 8'($urandom);
      mDmem[i] = int'(initMem[i]);
    end
    initMem[0] = 8'hFF; mDmem[0] = 255;
    for (int i = 0; i < 8; i++) mR[i] = 0;
    imem[0] = ins(2, 1, 5); imem[1] = ins(2, 1, 3); imem[2] = ins(0, 2, 1);
    imem[5] = ins(6, 1, 2);
    imem[10] = ins(1, 3, 4);
    imem[20] = ins(5, 1, 0); imem[21] = ins(2, 1, 1); imem[22] = ins(6, 1, 2); imem[23] = ins(2, 1, 3);
    imem[24] = ins(4, 1, 7); imem[25] = ins(6, 1, 2); imem[26] = ins(3, 1, 7); imem[27] = ins(6, 1, 2);
    imem[30] = ins(2, 3, 1); imem[31] = ins(7, 1, 2);
    imem[50] = ins(2, 4, 5); imem[51] = ins(4, 4, 4); imem[52] = ins(2, 4, 5); imem[53] = ins(2, 4, 5);
    imem[54] = ins(2, 5, 2); imem[55] = ins(4, 5, 4); imem[56] = ins(6, 4, 5); imem[57] = ins(5, 6, 5);
    imem[58] = ins(6, 6, 2);
    imem[60] = ins(5, 6, 5);
    imem[70] = ins(6, 4, 5);
    imem[10'h1C5] = ins(7, 1, 2);
    for (int i = 0; i < 8; i++) imem[900 + i] = ins(6, i, i);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_pc", 64'(imem_addr), 64'(0));
    chk("reset_cycles", 64'(cycles), 64'(0));
    chk("reset_retired", 64'(retired), 64'(0));
    chk("reset_we", 64'(dmem_we), 64'(0));
    chk("reset_re", 64'(dmem_re), 64'(0));
    reset = 1'b1; loadMem = 1'b0;
    @(negedge clk);
    runProg("basic", 0, 3, 1'b0, lat);
    chk("basic_retired3", 64'(retired), 64'(3));
    chk("basic_cycles7", 64'(cycles), 64'(7));
    runProg("show_r1", 5, 6, 1'b0, lat);
    chk("r1_r2_eq8", 64'(gotQ[gotQ.size() - 1]), 64'('h0808));
    gb = gotQ.size();
    runProg("alu_edge", 20, 28, 1'b0, lat);
    chk("addi_wrap", 64'(gotQ[gb]), 64'('h0800));
    chk("ls_fill", 64'(gotQ[gb + 1]), 64'('h0880));
    chk("andi_clear", 64'(gotQ[gb + 2]), 64'('h0800));
    runProg("beq_taken", 10, 7, 1'b0, lat);
    runProg("beq_not_taken", 30, 11, 1'b0, lat);
    runProg("jump", 'h1C5, 'h1CA, 1'b0, lat);
    chk("jump_target", 64'(imem_addr), 64'('h1CA));
    gb = gotQ.size();
    runProg("st_ld", 50, 59, 1'b1, lat);
    chk("st_event", 64'(gotQ[gb]), 64'('h205A));
    chk("ld_value", 64'(gotQ[gb + 1]), 64'('h085A));
    runProg("ld_only", 60, 61, 1'b0, lat);
    chk("ld_cycles", 64'(cycles), 64'(4));
    runProg("zero_len", 40, 40, 1'b0, lat);
    chk("zero_latency", 64'(lat), 64'(2));
    chk("zero_retired", 64'(retired), 64'(0));
    @(negedge clk); start_pc = 10'd70; end_pc = 10'd71; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("st_we_pre", 64'(dmem_we), 64'(1));
    chk("st_addr_pre", 64'(dmem_addr), 64'('h20));
    chk("st_data_pre", 64'(dmem_wdata), 64'('h5A));
    gb = gotQ.size();
    reset = 1'b0; #1;
    chk("rst_we_drop", 64'(dmem_we), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pc", 64'(imem_addr), 64'(0));
    chk("rst_cycles", 64'(cycles), 64'(0));
    chk("rst_retired", 64'(retired), 64'(0));
    chk("rst_addr", 64'(dmem_addr), 64'(0));
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 8; i++) mR[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_no_store", 64'(gotQ.size()), 64'(gb));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_done", 64'(done), 64'(0));
    runProg("restart", 70, 71, 1'b0, lat);
    chk("restart_store", 64'(gotQ[gotQ.size() - 1]), 64'(0));
    runProg("dump_after_reset", 900, 908, 1'b0, lat);
    for (int k = 0; k < 6; k++) begin
      base = 100 + 40 * k;
      for (int i = 0; i < 16; i++) begin
        rop = int'($urandom_range(6, 0));
        if (rop == 1 && i > 12) rop = 2;
        imem[base + i] = ins(rop, int'($urandom_range(7, 0)), rop == 1 ? int'($urandom_range(3, 0)) : int'($urandom_range(7, 0)));
      end
      runProg("random", base, base + 16, k % 2 == 1, lat);
      runProg("random_dump", 900, 908, 1'b0, lat);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
